stroke_painter: RTL
===================

// Module: stroke_painter
// PURPOSE
// - Downstream of user_input: turns cursor position/colour/stroke width into canvas write traffic.
// - While pen is down, stamps a square brush at the cursor into the canvas frame-buffer BRAM, one pixel per clock.
// - Also performs a full-canvas clear to background colour on request.
// - Feeds the canvas BRAM write port (port A); the video read-out uses the other port.
// PARAMETERS
// - H_ACTIVE  640    canvas width in pixels (cursor_loc_x range 0..H_ACTIVE-1)
// - V_ACTIVE  480    canvas height in pixels
// - BG_COLOR  4'h0   colour index written by a clear
// - ADDR_W    19     BRAM address width, >= clog2(H_ACTIVE*V_ACTIVE)
// PORTS
// - clk_in        in   1       system clock
// - rst_in        in   1       reset, asynchronous, active-high
// - cursor_loc_x  in   10      cursor column from user_input
// - cursor_loc_y  in   9       cursor row from user_input
// - cursor_color  in   4       brush colour index from user_input
// - stroke_width  in   3       brush size code w (0..7) from user_input
// - pen_down_in   in   1       level: drawing enabled
// - clear_in      in   1       single-cycle pulse: clear canvas
// - addr_out      out  ADDR_W  BRAM write address = y*H_ACTIVE + x
// - data_out      out  4       BRAM write data (colour index)
// - we_out        out  1       BRAM write enable
// - busy_out      out  1       high while state != IDLE
// BEHAVIOUR
// - One clock; rst_in is asynchronous, active-high. Reset: state IDLE, addr_out=0, data_out=0, we_out=0,
//   busy_out=0, last-stamp record invalid. Reset mid-stamp/clear drops we_out immediately; no resume.
// - States: IDLE, STAMP, CLEAR. All outputs registered.
// - Last-stamp record {x,y,color,width,valid}; valid cleared on reset, on any cycle with pen_down_in=0,
//   and on clear start.
// - Stamp trigger (IDLE only): pen_down_in=1 AND (!valid OR any of x/y/color/width differs from record).
//   On trigger edge: latch inputs into record (valid=1), dx=dy=0, go STAMP. Inputs ignored during STAMP.
// - Brush: side S=w+1, half=w>>1. Pixel (dx,dy), dx,dy in 0..w: px=x-half+dx, py=y-half+dy, 11-bit signed.
// - STAMP: one pixel per cycle, dx fastest. Each cycle registers addr_out, data_out=latched colour,
//   we_out=1 iff 0<=px<H_ACTIVE and 0<=py<V_ACTIVE; else we_out=0, addr_out don't-care.
//   Fixed length: S*S cycles regardless of clipping. First write visible one cycle after the trigger edge.
//   After pixel (w,w) is issued -> IDLE; we_out=0 next cycle. Back-to-back stamps allowed.
// - CLEAR: entered from any state on clear_in=1 (priority over trigger; aborts an active stamp on the
//   next edge). Writes BG_COLOR to addr 0..H_ACTIVE*V_ACTIVE-1, one per cycle, we_out=1 throughout.
//   clear_in during CLEAR restarts at addr 0. After last address -> IDLE.
// - pen_down_in falling mid-stamp: stamp completes; record invalidated.
// - Address arithmetic: y*H_ACTIVE as constant multiply, no DSP pipelining required at 100 MHz.
// STRUCTURE
// - canvas_pkg: H_ACTIVE, V_ACTIVE, CANVAS_PIXELS, color_t (logic [3:0]), painter_state_t enum.
// - Sub-module canvas_addr: (x,y) -> linear address, combinational; shared with the video read path.
// - Counters dx/dy (3 bits each) and clear counter (ADDR_W bits) live in stroke_painter.
// TESTING
// - Reset, pen up, inputs toggling 50 cycles -> we_out never high, busy_out=0, addr_out=0.
// - Pen down, (100,50), colour 5, w=0 -> exactly one write addr 32100 data 5; busy_out high 1 cycle.
// - Pen down, (0,0), w=2 -> 9 STAMP cycles, 4 writes: addr 0,1,640,641; data = colour.
// - Pen down, (639,479), w=3 -> 16 cycles, writes 306558,306559,307198,307199 only.
// - Pen held at (200,100) 100 cycles -> one stamp; colour 5->9 -> second stamp; pen up/down -> third.
// - clear_in mid-stamp -> next cycle CLEAR, 307200 writes data 0 addr 0..307199, then IDLE;
//   rst_in asserted mid-clear -> we_out=0 without waiting for a clock edge.

Source files
------------

// File: rtl/canvas_pkg.sv
// Shared canvas geometry, colour type and painter state encoding used by the
// stroke painter and the video read path.
package canvas_pkg;
    localparam int H_ACTIVE      = 640;
    localparam int V_ACTIVE      = 480;
    localparam int CANVAS_PIXELS = H_ACTIVE * V_ACTIVE;
    localparam int ADDR_W        = 19;

    typedef logic [3:0] color_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STAMP = 2'd1,
        ST_CLEAR = 2'd2
    } painter_state_t;
endpackage

// File: rtl/canvas_addr.sv
// Maps a canvas (x,y) coordinate to the linear frame-buffer address y*H_ACTIVE+x.
// Purely combinational so the video read path can share it.
module canvas_addr import canvas_pkg::*; #(
    parameter int H_ACTIVE = canvas_pkg::H_ACTIVE,
    parameter int ADDR_W   = canvas_pkg::ADDR_W
) (
    input  logic [9:0]        x,
    input  logic [8:0]        y,
    output logic [ADDR_W-1:0] addr
);
    assign addr = (ADDR_W'(y) * ADDR_W'(H_ACTIVE)) + ADDR_W'(x);
endmodule

// File: rtl/stroke_painter.sv
// Turns cursor position/colour/width into canvas BRAM write traffic: stamps a
// square brush one pixel per clock while the pen is down, and clears the canvas.
module stroke_painter import canvas_pkg::*; #(
    parameter int         H_ACTIVE = canvas_pkg::H_ACTIVE,
    parameter int         V_ACTIVE = canvas_pkg::V_ACTIVE,
    parameter logic [3:0] BG_COLOR = 4'h0,
    parameter int         ADDR_W   = canvas_pkg::ADDR_W
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [9:0]        cursor_loc_x,
    input  logic [8:0]        cursor_loc_y,
    input  logic [3:0]        cursor_color,
    input  logic [2:0]        stroke_width,
    input  logic              pen_down_in,
    input  logic              clear_in,
    output logic [ADDR_W-1:0] addr_out,
    output logic [3:0]        data_out,
    output logic              we_out,
    output logic              busy_out
);
    localparam int PIXELS = H_ACTIVE * V_ACTIVE;

    painter_state_t    state_r, state_s;
    logic [9:0]        x_r;
    logic [8:0]        y_r;
    color_t            color_r;
    logic [2:0]        width_r;
    logic              valid_r;
    logic [2:0]        dx_r, dy_r, dx_s, dy_s;
    logic [ADDR_W-1:0] clr_cnt_r, clr_cnt_s;
    logic [ADDR_W-1:0] addr_s;
    logic [3:0]        data_s;
    logic              we_s;
    logic              latch_s;
    logic              trigger_s;
    logic              last_pix_s;
    logic              last_clr_s;
    logic              in_range_s;
    logic [10:0]       px_s, py_s;
    logic [ADDR_W-1:0] pix_addr_s;

    // Brush pixel position; negative results wrap so bit 10 flags "left/above the canvas".
    assign px_s = {1'b0, x_r} - {9'd0, width_r[2:1]} + {8'd0, dx_r};
    assign py_s = {2'b00, y_r} - {9'd0, width_r[2:1]} + {8'd0, dy_r};
    assign in_range_s = !px_s[10] && (px_s < 11'(H_ACTIVE)) &&
                        !py_s[10] && (py_s < 11'(V_ACTIVE));

    assign trigger_s  = pen_down_in && (!valid_r ||
                        (cursor_loc_x != x_r) || (cursor_loc_y != y_r) ||
                        (cursor_color != color_r) || (stroke_width != width_r));
    assign last_pix_s = (dx_r == width_r) && (dy_r == width_r);
    assign last_clr_s = (clr_cnt_r == ADDR_W'(PIXELS - 1));

    canvas_addr #(
        .H_ACTIVE (H_ACTIVE),
        .ADDR_W   (ADDR_W)
    ) u_canvas_addr (
        .x    (px_s[9:0]),
        .y    (py_s[8:0]),
        .addr (pix_addr_s)
    );

    // Next-state and next-output selection; clear request overrides everything.
    always_comb begin
        state_s   = state_r;
        dx_s      = dx_r;
        dy_s      = dy_r;
        clr_cnt_s = clr_cnt_r;
        addr_s    = addr_out;
        data_s    = data_out;
        we_s      = 1'b0;
        latch_s   = 1'b0;
        if (clear_in) begin
            state_s   = ST_CLEAR;
            clr_cnt_s = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (trigger_s) begin
                        state_s = ST_STAMP;
                        dx_s    = 3'd0;
                        dy_s    = 3'd0;
                        latch_s = 1'b1;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_STAMP: begin
                    addr_s = pix_addr_s;
                    data_s = color_r;
                    we_s   = in_range_s;
                    if (last_pix_s) begin
                        state_s = ST_IDLE;
                    end else if (dx_r == width_r) begin
                        dx_s = 3'd0;
                        dy_s = dy_r + 3'd1;
                    end else begin
                        dx_s = dx_r + 3'd1;
                    end
                end
                ST_CLEAR: begin
                    addr_s = clr_cnt_r;
                    data_s = BG_COLOR;
                    we_s   = 1'b1;
                    if (last_clr_s) begin
                        state_s = ST_IDLE;
                    end else begin
                        clr_cnt_s = clr_cnt_r + ADDR_W'(1);
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // State, counters and registered BRAM port outputs.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_r   <= ST_IDLE;
            dx_r      <= 3'd0;
            dy_r      <= 3'd0;
            clr_cnt_r <= '0;
            addr_out  <= '0;
            data_out  <= 4'h0;
            we_out    <= 1'b0;
            busy_out  <= 1'b0;
        end else begin
            state_r   <= state_s;
            dx_r      <= dx_s;
            dy_r      <= dy_s;
            clr_cnt_r <= clr_cnt_s;
            addr_out  <= addr_s;
            data_out  <= data_s;
            we_out    <= we_s;
            busy_out  <= (state_s != ST_IDLE);
        end
    end

    // Last-stamp record: any pen-up cycle or clear forgets it so the next pen-down restamps.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            x_r     <= 10'd0;
            y_r     <= 9'd0;
            color_r <= 4'h0;
            width_r <= 3'd0;
            valid_r <= 1'b0;
        end else if (clear_in || !pen_down_in) begin
            valid_r <= 1'b0;
        end else if (latch_s) begin
            x_r     <= cursor_loc_x;
            y_r     <= cursor_loc_y;
            color_r <= cursor_color;
            width_r <= stroke_width;
            valid_r <= 1'b1;
        end else begin
            valid_r <= valid_r;
        end
    end
endmodule
